// File: rtl/debounce_multi.sv
// N-channel debouncer: per-channel synchroniser, polarity normalisation and hold counter.
// MODE 0 asserts at once and stretches the release; MODE 1 filters both edges.
module debounce_multi #(
  parameter int CH          = 4,
  parameter int HOLD_CYC    = 262144,
  parameter int SYNC_STAGES = 2,
  parameter bit ACTIVE_LOW  = 1'b0,
  parameter bit MODE        = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic [CH-1:0] btn,
  output logic [CH-1:0] level,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          busy
);

  localparam int              CNT_W     = $clog2(HOLD_CYC + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

  logic [CH-1:0]    sync_q [SYNC_STAGES];
  logic [CH-1:0]    s;
  logic [CNT_W-1:0] cnt_q  [CH];
  logic [CNT_W-1:0] cnt_d  [CH];
  logic [CH-1:0]    level_d;

  // Synchroniser resets to the idle pin level so the normalised sample starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= {CH{ACTIVE_LOW}};
    end else begin
      sync_q[0] <= btn;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1] ^ {CH{ACTIVE_LOW}};

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      cnt_d[i]   = cnt_q[i];
      level_d[i] = level[i];
      if (MODE == 1'b0) begin
        if (s[i]) begin
          level_d[i] = 1'b1;
          cnt_d[i]   = '0;
        end else if (level[i]) begin
          if (tick) begin
            if (cnt_q[i] == HOLD_LAST) begin
              level_d[i] = 1'b0;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
        end else begin
          cnt_d[i] = '0;
        end
      end else begin
        if (s[i] == level[i]) begin
          cnt_d[i] = '0;
        end else if (tick) begin
          if (cnt_q[i] == HOLD_LAST) begin
            level_d[i] = s[i];
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Strobes are derived from the level transition so they align with its first new cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) cnt_q[i] <= '0;
      level <= '0;
      rise  <= '0;
      fall  <= '0;
    end else begin
      for (int i = 0; i < CH; i++) cnt_q[i] <= cnt_d[i];
      level <= level_d;
      rise  <= level_d & ~level;
      fall  <= ~level_d & level;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < CH; i++) busy = busy | (cnt_q[i] != '0);
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised N-channel button/switch debouncer for asynchronous mechanical inputs.
- Each channel has an input synchroniser, a polarity normaliser, a per-channel hold counter and two filter modes: stretch and symmetric.
- Outputs are a clean level plus single-cycle rise/fall strobes per channel.
- Sits between board pins and control logic (mode/seed selection, LED pattern stepping).

Parameters:
- CH, 4, number of independent channels.
- HOLD_CYC, 262144, qualifying ticks required to release (mode 0) or to change state (mode 1); legal range is 1 or more.
- SYNC_STAGES, 2, synchroniser flop depth per channel; legal range is 2 or more.
- ACTIVE_LOW, 0, 1 means a pressed input reads as 0; the input is inverted after synchronisation.
- MODE, 0, 0 = stretch (assert immediately, delayed release); 1 = symmetric (both edges filtered).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  counter enable/prescale strobe; tie to 1 to count every clk.
- btn  input  CH  raw asynchronous inputs.
- level  output  CH  debounced state, 1 = pressed.
- rise  output  CH  one-cycle strobe marking the first cycle level[i]=1.
- fall  output  CH  one-cycle strobe marking the first cycle level[i]=0.
- busy  output  1  OR over channels of (counter != 0).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Synchroniser flops load ACTIVE_LOW, so the normalised value is 0.
  - level, rise, fall, all counters and busy clear to 0.
  - Deassertion is not internally synchronised. The integrator supplies a reset that is synchronously released.
- Normalised sample: s[i] = last synchroniser stage XOR ACTIVE_LOW. s lags btn by SYNC_STAGES clks.
- Counter width: CNT_W = clog2(HOLD_CYC+1). Every channel's counter is independent and never wraps.
- MODE 0 (stretch), per channel, evaluated in priority order each clk:
  - s=1: level<=1 and cnt<=0, regardless of tick.
  - Otherwise, if level=1 and tick=1:
    - cnt==HOLD_CYC-1: level<=0, cnt<=0.
    - Else cnt<=cnt+1.
  - Otherwise, if level=0: cnt<=0.
  - Net effect: level rises SYNC_STAGES+1 clks after the btn edge. level falls once s has been 0 for HOLD_CYC consecutive tick cycles. Any s=1 restarts the hold.
- MODE 1 (symmetric), per channel:
  - s==level: cnt<=0.
  - Else, if tick=1:
    - cnt==HOLD_CYC-1: level<=s, cnt<=0.
    - Else cnt<=cnt+1.
  - Else (tick=0): cnt holds.
  - A mismatch shorter than HOLD_CYC ticks produces no change and clears cnt on return to agreement.
- Strobes:
  - rise[i] and fall[i] are registered: rise[i]=1 exactly in the first cycle level[i] is 1, fall[i] likewise for 0.
  - They never assert together, never assert for two consecutive cycles on one channel, and never assert out of reset.
- HOLD_CYC=1:
  - Mode 1: level follows s one clk later whenever tick=1.
  - Mode 0: release occurs on the first tick with s=0.
- tick=0 held: counters freeze. Mode 0 assertion still proceeds.
- Channels are fully independent. Simultaneous events on several channels all take effect in the same cycle.
- busy is combinational from counter state. No other combinational input-to-output path exists.
- Reset mid-count: counter and level return to 0 immediately. No strobe is emitted for the reset-induced drop.

Test Plan:
- MODE 0, CH=4, HOLD_CYC=4, SYNC_STAGES=2, tick=1. btn[0] 0->1 at clk 10 -> level[0]=1 and rise[0]=1 at clk 13, rise[0]=0 at clk 14. btn[0] ->0 at clk 20 -> level[0] falls at clk 26 with fall[0]=1 for one cycle.
- MODE 0 bounce: btn[1] pulses 1,0,1,0 every clk, then stays 0 -> level[1] rises once, exactly one rise and one fall strobe. Fall occurs 4 ticks after the last s=1.
- MODE 1, HOLD_CYC=4: btn[2] high for 3 clks -> no level change, busy returns to 0. btn[2] high for 6 clks -> level[2]=1 exactly 2+4 clks after the edge, single rise strobe.
- tick every 3rd clk, MODE 1, HOLD_CYC=4: btn[3] held high -> level[3] rises on the 4th tick after s=1, not earlier. Counter holds between ticks.
- ACTIVE_LOW=1: btn idle 1 after reset -> level=0 and no strobes. btn[0] driven to 0 -> behaves as a press.
- Async reset: assert rst_n=0 mid-count with level=1 -> level, cnt and busy are 0 without a clk edge. No fall strobe is emitted after release. Simultaneous btn edges on all channels produce rise strobes in the same cycle.
